mgmt_wb_slave_mux: RTL and testbench



---
 rtl/mgmt_wb_slave_mux.sv | 229 ++++++++++++++++++++++
 tb/tb_mgmt_wb_slave_mux.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mgmt_wb_slave_mux.sv
// ============================================================================
// Module   : mgmt_wb_slave_mux
// Purpose  : Management wishbone fan-out to NUM_SLAVES slaves with base/mask
//            decode, registered request/response stages and an optional bus
//            watchdog enabled by defining MGMT_WB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mgmt_wb_slave_mux #(
    parameter int NUM_SLAVES     = 2,
    parameter int ADR_W          = 32,
    parameter int DAT_W          = 32,
    // Slot 0 occupies the low bits: user project window at 0x3000_0000.
    parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_BASE = {32'h2600_0000, 32'h3000_0000},
    parameter logic [NUM_SLAVES*ADR_W-1:0] SLAVE_MASK = {32'hFFF0_0000, 32'hFF00_0000},
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        core_clk,
    input  logic                        core_rst,
    input  logic                        m_cyc_i,
    input  logic                        m_stb_i,
    input  logic                        m_we_i,
    input  logic [DAT_W/8-1:0]          m_sel_i,
    input  logic [ADR_W-1:0]            m_adr_i,
    input  logic [DAT_W-1:0]            m_dat_i,
    output logic                        m_ack_o,
    output logic                        m_err_o,
    output logic [DAT_W-1:0]            m_dat_o,
    output logic [NUM_SLAVES-1:0]       s_cyc_o,
    output logic [NUM_SLAVES-1:0]       s_stb_o,
    output logic [NUM_SLAVES-1:0]       s_iena_o,
    output logic                        s_we_o,
    output logic [DAT_W/8-1:0]          s_sel_o,
    output logic [ADR_W-1:0]            s_adr_o,
    output logic [DAT_W-1:0]            s_dat_o,
    input  logic [NUM_SLAVES-1:0]       s_ack_i,
    input  logic [NUM_SLAVES*DAT_W-1:0] s_dat_i,
    output logic                        timeout_flag_o,
    output logic [ADR_W-1:0]            timeout_adr_o,
    input  logic                        timeout_clr_i
);

    localparam int SEL_W = DAT_W / 8;
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    m_ack_q, m_ack_d;
    logic                    m_err_q, m_err_d;
    logic [DAT_W-1:0]        m_dat_q, m_dat_d;
    logic [NUM_SLAVES-1:0]   s_req_q, s_req_d;
    logic                    s_we_q, s_we_d;
    logic [SEL_W-1:0]        s_sel_q, s_sel_d;
    logic [ADR_W-1:0]        s_adr_q, s_adr_d;
    logic [DAT_W-1:0]        s_dat_q, s_dat_d;
    logic [IDX_W-1:0]        sel_idx_q, sel_idx_d;

    logic                    w_hit;
    logic [IDX_W-1:0]        w_hit_idx;
    logic [NUM_SLAVES-1:0]   w_hit_onehot;
    logic                    w_sel_ack;
    logic                    w_timeout;
    logic [DAT_W-1:0]        w_s_dat [NUM_SLAVES];

    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_unpack
        assign w_s_dat[gi] = s_dat_i[gi*DAT_W +: DAT_W];
    end

    // Scan from the top down so the lowest-numbered matching slot wins.
    always_comb begin
        w_hit        = 1'b0;
        w_hit_idx    = '0;
        w_hit_onehot = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((m_adr_i & SLAVE_MASK[i*ADR_W +: ADR_W]) ==
                (SLAVE_BASE[i*ADR_W +: ADR_W] & SLAVE_MASK[i*ADR_W +: ADR_W])) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
        w_hit_onehot[w_hit_idx] = w_hit;
    end

    assign w_sel_ack = s_ack_i[sel_idx_q];

`ifdef MGMT_WB_TIMEOUT_EN
    logic [15:0]      cnt_q;
    logic             to_flag_q;
    logic [ADR_W-1:0] to_adr_q;
    logic             w_fire;

    assign w_timeout = (cnt_q == 16'(TIMEOUT_CYCLES));
    assign w_fire    = (state_q == S_REQ) && m_cyc_i && !w_sel_ack && w_timeout;

    always_ff @(posedge core_clk) begin
        if (core_rst || state_q != S_REQ) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    // A timeout in the same cycle as a clear request keeps the flag set.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            to_flag_q <= 1'b0;
            to_adr_q  <= '0;
        end else if (w_fire) begin
            to_flag_q <= 1'b1;
            if (!to_flag_q) begin
                to_adr_q <= s_adr_q;
            end
        end else if (timeout_clr_i) begin
            to_flag_q <= 1'b0;
            to_adr_q  <= '0;
        end
    end

    assign timeout_flag_o = to_flag_q;
    assign timeout_adr_o  = to_adr_q;
`else
    logic        unused_clr;
    logic [15:0] unused_timeout;

    assign unused_clr     = timeout_clr_i;
    assign unused_timeout = 16'(TIMEOUT_CYCLES);
    assign w_timeout      = 1'b0;
    assign timeout_flag_o = 1'b0;
    assign timeout_adr_o  = '0;
`endif

    always_comb begin
        state_d   = state_q;
        m_ack_d   = 1'b0;
        m_err_d   = 1'b0;
        m_dat_d   = m_dat_q;
        s_req_d   = s_req_q;
        s_we_d    = s_we_q;
        s_sel_d   = s_sel_q;
        s_adr_d   = s_adr_q;
        s_dat_d   = s_dat_q;
        sel_idx_d = sel_idx_q;
        case (state_q)
            S_IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    if (w_hit) begin
                        s_we_d    = m_we_i;
                        s_sel_d   = m_sel_i;
                        s_adr_d   = m_adr_i;
                        s_dat_d   = m_dat_i;
                        sel_idx_d = w_hit_idx;
                        s_req_d   = w_hit_onehot;
                        state_d   = S_REQ;
                    end else begin
                        m_ack_d = 1'b1;
                        m_err_d = 1'b1;
                        m_dat_d = '1;
                        state_d = S_RESP;
                    end
                end
            end
            S_REQ: begin
                if (!m_cyc_i) begin
                    s_req_d = '0;
                    state_d = S_IDLE;
                end else if (w_sel_ack) begin
                    s_req_d = '0;
                    m_ack_d = 1'b1;
                    m_dat_d = s_we_q ? '0 : w_s_dat[sel_idx_q];
                    state_d = S_RESP;
                end else if (w_timeout) begin
                    s_req_d = '0;
                    m_ack_d = 1'b1;
                    m_err_d = 1'b1;
                    m_dat_d = '1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q   <= S_IDLE;
            m_ack_q   <= 1'b0;
            m_err_q   <= 1'b0;
            m_dat_q   <= '0;
            s_req_q   <= '0;
            s_we_q    <= 1'b0;
            s_sel_q   <= '0;
            s_adr_q   <= '0;
            s_dat_q   <= '0;
            sel_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            m_ack_q   <= m_ack_d;
            m_err_q   <= m_err_d;
            m_dat_q   <= m_dat_d;
            s_req_q   <= s_req_d;
            s_we_q    <= s_we_d;
            s_sel_q   <= s_sel_d;
            s_adr_q   <= s_adr_d;
            s_dat_q   <= s_dat_d;
            sel_idx_q <= sel_idx_d;
        end
    end

    assign m_ack_o  = m_ack_q;
    assign m_err_o  = m_err_q;
    assign m_dat_o  = m_dat_q;
    assign s_cyc_o  = s_req_q;
    assign s_stb_o  = s_req_q;
    assign s_iena_o = s_req_q;
    assign s_we_o   = s_we_q;
    assign s_sel_o  = s_sel_q;
    assign s_adr_o  = s_adr_q;
    assign s_dat_o  = s_dat_q;

endmodule

`default_nettype wire

// File: tb/tb_mgmt_wb_slave_mux.sv
// ============================================================================
// Module   : tb_mgmt_wb_slave_mux
// Purpose  : Self-checking bench for mgmt_wb_slave_mux (vector table, hand
//            sequences for abort/reset/watchdog, randomized reference check).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mgmt_wb_slave_mux;

    localparam int N  = 2;
    localparam int TO = 8;
    localparam logic [63:0] BASE = {32'h2600_0000, 32'h3000_0000};
    localparam logic [63:0] MASK = {32'hFFF0_0000, 32'hFF00_0000};

    logic        core_clk, core_rst;
    logic        m_cyc, m_stb, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_adr, m_dat_w;
    logic        m_ack_o, m_err_o;
    logic [31:0] m_dat_o;
    logic [1:0]  s_cyc_o, s_stb_o, s_iena_o, s_ack;
    logic        s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [63:0] s_dat_i;
    logic        timeout_flag_o, timeout_clr;
    logic [31:0] timeout_adr_o;

    logic [1:0]  ack_en, spurious;
    logic [31:0] rdata [N];

    int checks = 0;
    int errors = 0;

    assign s_ack   = (s_stb_o & ack_en) | spurious;
    assign s_dat_i = {rdata[1], rdata[0]};

    mgmt_wb_slave_mux #(
        .NUM_SLAVES(N), .ADR_W(32), .DAT_W(32),
        .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(TO)
    ) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_adr_i(m_adr), .m_dat_i(m_dat_w),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_dat_o(m_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_iena_o(s_iena_o),
        .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack), .s_dat_i(s_dat_i),
        .timeout_flag_o(timeout_flag_o), .timeout_adr_o(timeout_adr_o),
        .timeout_clr_i(timeout_clr)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish in time");
        $fatal(1, "time limit");
    end

    typedef struct {
        bit          got;
        int          lat;
        logic        err;
        logic [31:0] mdat;
        logic [1:0]  stb, iena, cyc;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr, dat;
        logic        ack_after;
        logic        flag;
        logic [31:0] toadr;
    } res_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          delay;
        logic        err;
        logic [31:0] edat;
        int          lat;
        logic [1:0]  stb;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Address decode straight from the base/mask table: first matching slot, else -1.
    function automatic int ref_slave(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if ((a & MASK[i*32 +: 32]) == (BASE[i*32 +: 32] & MASK[i*32 +: 32])) return i;
        return -1;
    endfunction

    // delay: extra REQ cycles before the slave acks; -1 means it never acks.
    task automatic do_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, input int delay, output res_t r);
        int cyc = 0;
        int k = 0;
        r = '{default: '0};
        @(posedge core_clk); #1;
        ack_en = {2{delay == 0}};
        m_cyc = 1'b1; m_stb = 1'b1; m_we = we; m_sel = sel; m_adr = adr; m_dat_w = dat;
        while (cyc < 40 && !r.got) begin
            @(posedge core_clk); #1;
            cyc++;
            if (|s_stb_o) begin
                k++;
                if (k == 1) begin
                    r.stb = s_stb_o; r.iena = s_iena_o; r.cyc = s_cyc_o;
                    r.we = s_we_o; r.sel = s_sel_o; r.adr = s_adr_o; r.dat = s_dat_o;
                end
                if (delay >= 0 && k > delay) ack_en = 2'b11;
            end
            if (m_ack_o) begin
                r.got = 1'b1; r.lat = cyc; r.err = m_err_o; r.mdat = m_dat_o;
                r.flag = timeout_flag_o; r.toadr = timeout_adr_o;
            end
        end
        m_cyc = 1'b0; m_stb = 1'b0; ack_en = 2'b00; spurious = 2'b00;
        @(posedge core_clk); #1;
        r.ack_after = m_ack_o;
    endtask

    task automatic check_txn(input string tag, input res_t r, input logic e_err,
                             input logic [31:0] e_dat, input int e_lat, input logic [1:0] e_stb,
                             input logic we, input logic [3:0] sel,
                             input logic [31:0] adr, input logic [31:0] dat);
        check({tag, "_acked"}, 64'(r.got), 64'd1);
        check({tag, "_latency"}, 64'(r.lat), 64'(e_lat));
        check({tag, "_err"}, 64'(r.err), 64'(e_err));
        check({tag, "_mdat"}, 64'(r.mdat), 64'(e_dat));
        check({tag, "_stb_cyc_iena"}, {r.stb, r.cyc, r.iena}, {e_stb, e_stb, e_stb});
        check({tag, "_ack_single"}, 64'(r.ack_after), 64'd0);
        if (e_stb != 2'b00)
            check({tag, "_fields"}, {r.we, r.sel, r.adr}, {we, sel, adr});
        if (e_stb != 2'b00 && we)
            check({tag, "_wdata"}, 64'(r.dat), 64'(dat));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctl"}, {m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_iena_o, s_we_o, s_sel_o, timeout_flag_o}, 64'd0);
        check({tag, "_mdat"}, 64'(m_dat_o), 64'd0);
        check({tag, "_sadr_sdat"}, {s_adr_o, s_dat_o}, 64'd0);
        check({tag, "_toadr"}, 64'(timeout_adr_o), 64'd0);
    endtask

    vec_t vecs [6];
    res_t r;

    initial begin
        vecs[0] = '{1'b0, 32'h3000_0004, 4'hF, 32'h0,         0, 1'b0, 32'hDEAD_BEEF, 2, 2'b01};
        vecs[1] = '{1'b1, 32'h2600_0010, 4'h3, 32'h1234_5678, 0, 1'b0, 32'h0,         2, 2'b10};
        vecs[2] = '{1'b0, 32'h1000_0000, 4'hF, 32'h0,         0, 1'b1, 32'hFFFF_FFFF, 1, 2'b00};
        vecs[3] = '{1'b0, 32'h2600_0010, 4'hF, 32'h0,         3, 1'b0, 32'hCAFE_F00D, 5, 2'b10};
        vecs[4] = '{1'b1, 32'h2610_0000, 4'h1, 32'h5555_AAAA, 0, 1'b1, 32'hFFFF_FFFF, 1, 2'b00};
        vecs[5] = '{1'b0, 32'h30FF_FFFC, 4'hC, 32'h0,         1, 1'b0, 32'hDEAD_BEEF, 3, 2'b01};

        m_cyc = 0; m_stb = 0; m_we = 0; m_sel = 0; m_adr = 0; m_dat_w = 0;
        ack_en = 0; spurious = 0; timeout_clr = 0;
        rdata[0] = 32'hDEAD_BEEF; rdata[1] = 32'hCAFE_F00D;
        core_rst = 1'b1;
        repeat (3) @(posedge core_clk);
        #1;
        check_zero_outputs("reset");
        core_rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].delay, r);
            check_txn($sformatf("vec%0d", i), r, vecs[i].err, vecs[i].edat, vecs[i].lat,
                      vecs[i].stb, vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat);
        end

        // Master drops cyc while the slave stalls.
        begin
            int  wait_cyc;
            bit  any_ack = 0;
`ifdef MGMT_WB_TIMEOUT_EN
            wait_cyc = 3;
`else
            wait_cyc = 20;
`endif
            @(posedge core_clk); #1;
            m_cyc = 1; m_stb = 1; m_we = 0; m_sel = 4'hF; m_adr = 32'h2600_0020; ack_en = 0;
            repeat (wait_cyc) begin
                @(posedge core_clk); #1;
                if (m_ack_o) any_ack = 1;
            end
            check("abort_stall_stb", 64'(s_stb_o), 64'd2);
            check("abort_flag_idle", 64'(timeout_flag_o), 64'd0);
            m_cyc = 0; m_stb = 0;
            @(posedge core_clk); #1;
            check("abort_strobes_clear", {s_cyc_o, s_stb_o, s_iena_o}, 64'd0);
            repeat (3) begin
                if (m_ack_o) any_ack = 1;
                @(posedge core_clk); #1;
            end
            check("abort_no_ack", 64'(any_ack), 64'd0);
            do_txn(1'b0, 32'h3000_0008, 4'hF, 32'h0, 0, r);
            check_txn("after_abort", r, 1'b0, 32'hDEAD_BEEF, 2, 2'b01, 1'b0, 4'hF, 32'h3000_0008, 32'h0);
        end

        // Reset asserted while a request is outstanding.
        @(posedge core_clk); #1;
        m_cyc = 1; m_stb = 1; m_we = 1; m_sel = 4'hF; m_adr = 32'h2600_0044; m_dat_w = 32'h0BAD_F00D; ack_en = 0;
        repeat (3) @(posedge core_clk);
        #1;
        check("prerst_in_req", 64'(s_stb_o), 64'd2);
        core_rst = 1;
        @(posedge core_clk); #1;
        check_zero_outputs("midrst");
        core_rst = 0; m_cyc = 0; m_stb = 0;
        do_txn(1'b0, 32'h2600_0004, 4'hF, 32'h0, 0, r);
        check_txn("after_rst", r, 1'b0, 32'hCAFE_F00D, 2, 2'b10, 1'b0, 4'hF, 32'h2600_0004, 32'h0);

`ifdef MGMT_WB_TIMEOUT_EN
        do_txn(1'b0, 32'h2600_0020, 4'hF, 32'h0, -1, r);
        check_txn("to1", r, 1'b1, 32'hFFFF_FFFF, TO + 2, 2'b10, 1'b0, 4'hF, 32'h2600_0020, 32'h0);
        check("to1_flag_adr", {r.flag, r.toadr}, {1'b1, 32'h2600_0020});
        do_txn(1'b0, 32'h2600_0030, 4'hF, 32'h0, -1, r);
        check("to2_err", 64'(r.err), 64'd1);
        check("to2_flag_adr", {r.flag, r.toadr}, {1'b1, 32'h2600_0020});
        timeout_clr = 1;
        @(posedge core_clk); #1;
        timeout_clr = 0;
        check("to_clear", {timeout_flag_o, timeout_adr_o}, 64'd0);
        timeout_clr = 1;
        do_txn(1'b0, 32'h2600_0040, 4'hF, 32'h0, -1, r);
        timeout_clr = 0;
        check("to3_set_beats_clr", {r.flag, r.toadr}, {1'b1, 32'h2600_0040});
        timeout_clr = 1;
        @(posedge core_clk); #1;
        timeout_clr = 0;
`endif

        // Randomized traffic against the decode reference.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a, d;
            logic        w;
            logic [3:0]  s;
            int          dly, idx;
            logic [1:0]  e_stb;
            logic [31:0] e_dat;
            case ($urandom_range(0, 2))
                0:       a = {8'h30, 24'($urandom)};
                1:       a = {12'h260, 20'($urandom)};
                default: a = $urandom;
            endcase
            d = $urandom; w = 1'($urandom); s = 4'($urandom); dly = $urandom_range(0, 3);
            rdata[0] = $urandom; rdata[1] = $urandom;
            idx = ref_slave(a);
            e_stb = (idx < 0) ? 2'b00 : 2'(1 << idx);
            spurious = 2'($urandom) & ~e_stb;
            if (idx < 0)  e_dat = 32'hFFFF_FFFF;
            else if (w)   e_dat = 32'h0;
            else          e_dat = rdata[idx];
            do_txn(w, a, s, d, dly, r);
            check_txn($sformatf("rnd%0d", n), r, idx < 0, e_dat, (idx < 0) ? 1 : dly + 2,
                      e_stb, w, s, a, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
